// File: rtl/spi_baud_rate_gen.sv
// SPI master SCLK generator with sample/shift strobes; strobes are combinational in the toggling cycle.
// Optional macro SPI_BRG_EDGE_CNT_EN adds edge_cnt, a saturating count of SCLK edges since entering RUN.
module spi_baud_rate_gen #(
   parameter int DIV_W = 12
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic [1:0]       spi_mode,
   input  logic             spiswai,
   input  logic [2:0]       sppr,
   input  logic [2:0]       spr,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             ss,
   output logic             sclk,
   output logic             sample_pulse,
   output logic             shift_pulse,
`ifdef SPI_BRG_EDGE_CNT_EN
   output logic [4:0]       edge_cnt,
`endif
   output logic [DIV_W-1:0] baud_rate_divisor
);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q;
   logic [DIV_W-1:0] count_q;
   logic             sclk_q;
   logic [DIV_W-1:0] base;
   logic [DIV_W-1:0] half;
   logic             active;
   logic             terminal;
   logic             strobe;
   logic             leading;

   assign base              = DIV_W'(sppr) + DIV_W'(1);
   assign half              = base << spr;
   assign baud_rate_divisor = base << ({1'b0, spr} + 4'd1);

   assign active   = !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
   assign terminal = count_q >= half - DIV_W'(1);

   // The registered RUN state keeps the strobe alive in the cycle where active drops.
   assign strobe       = !PRESET && (active || state_q == RUN) && terminal;
   assign leading      = (sclk_q == cpol);
   assign sample_pulse = strobe && (leading ^ cpha);
   assign shift_pulse  = strobe && !(leading ^ cpha);
   assign sclk         = sclk_q;

`ifdef SPI_BRG_EDGE_CNT_EN
   logic [4:0] edge_q;
   assign edge_cnt = edge_q;

   always_ff @(posedge PCLK) begin
      if (PRESET || !active) begin
         edge_q <= 5'd0;
      end else if (terminal && edge_q != 5'd16) begin
         edge_q <= edge_q + 5'd1;
      end
   end
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET || !active) begin
         state_q <= IDLE;
         count_q <= '0;
         sclk_q  <= cpol;
      end else begin
         state_q <= RUN;
         if (terminal) begin
            count_q <= '0;
            sclk_q  <= ~sclk_q;
         end else begin
            count_q <= count_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_spi_baud_rate_gen.sv
// Scoreboard bench for spi_baud_rate_gen: per-cycle expectations queued from a behavioural model.
// Define SPI_BRG_EDGE_CNT_EN to also exercise edge_cnt.
module tb_spi_baud_rate_gen;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic [1:0]  spi_mode;
   logic        spiswai;
   logic [2:0]  sppr;
   logic [2:0]  spr;
   logic        cpol;
   logic        cpha;
   logic        ss;
   logic        sclk;
   logic        sample_pulse;
   logic        shift_pulse;
   logic [11:0] baud_rate_divisor;
   logic [4:0]  obs_edge;

`ifdef SPI_BRG_EDGE_CNT_EN
   logic [4:0] edge_cnt;
   assign obs_edge = edge_cnt;
   localparam bit HAS_EDGE = 1'b1;
`else
   assign obs_edge = 5'd0;
   localparam bit HAS_EDGE = 1'b0;
`endif

   spi_baud_rate_gen #(.DIV_W(12)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .spi_mode(spi_mode), .spiswai(spiswai),
      .sppr(sppr), .spr(spr), .cpol(cpol), .cpha(cpha), .ss(ss),
      .sclk(sclk), .sample_pulse(sample_pulse), .shift_pulse(shift_pulse),
`ifdef SPI_BRG_EDGE_CNT_EN
      .edge_cnt(edge_cnt),
`endif
      .baud_rate_divisor(baud_rate_divisor)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   // Model state, mirrors the behaviour described for SCLK generation
   int   m_cnt  = 0;
   logic m_sclk = 1'b0;
   logic m_run  = 1'b0;
   int   m_edge = 0;

   logic [19:0] exp_q[$];
   logic [19:0] obs_q[$];

   logic       o_sclk, o_smp, o_shf;
   logic [11:0] o_div;
   logic [4:0] o_edge;

   // One PCLK cycle: inputs are already driven; queue expected and observed, then advance.
   task automatic tick();
      int   h, dv, n_cnt, n_edge;
      logic act, term, strb, lead, smp, shf, n_sclk, n_run;
      logic [4:0] e_edge;
      #1;
      h    = (int'(sppr) + 1) << spr;
      dv   = (int'(sppr) + 1) << (int'(spr) + 1);
      act  = !ss && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
      term = (m_cnt >= h - 1);
      strb = !PRESET && (act || m_run) && term;
      lead = (m_sclk == cpol);
      smp  = strb && (cpha ? !lead : lead);
      shf  = strb && (cpha ? lead : !lead);
      e_edge = HAS_EDGE ? m_edge[4:0] : 5'd0;
      exp_q.push_back({e_edge, m_sclk, smp, shf, dv[11:0]});
      obs_q.push_back({obs_edge, sclk, sample_pulse, shift_pulse, baud_rate_divisor});
      o_sclk = sclk; o_smp = sample_pulse; o_shf = shift_pulse;
      o_div = baud_rate_divisor; o_edge = obs_edge;
      n_cnt = m_cnt; n_sclk = m_sclk; n_run = m_run; n_edge = m_edge;
      if (PRESET || !act) begin
         n_cnt = 0; n_sclk = cpol; n_run = 1'b0; n_edge = 0;
      end else begin
         n_run = 1'b1;
         if (term) begin
            n_cnt  = 0;
            n_sclk = ~m_sclk;
            n_edge = (m_edge < 16) ? m_edge + 1 : 16;
         end else begin
            n_cnt = m_cnt + 1;
         end
      end
      @(posedge PCLK);
      m_cnt = n_cnt; m_sclk = n_sclk; m_run = n_run; m_edge = n_edge;
      @(negedge PCLK);
   endtask

   task automatic test_reset();
      logic [19:0] e, o;
      PRESET = 1'b1; cpol = 1'b1; sppr = 3'd3; spr = 3'd2; cpha = 1'b0;
      spi_mode = 2'b00; spiswai = 1'b0; ss = 1'b0;
      tick();
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (o_sclk !== 1'b1 || o_smp !== 1'b0 || o_shf !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold k=%0d: sclk/smp/shf=%b%b%b want 100", k, o_sclk, o_smp, o_shf);
         end
      end
      total++;
      if (o_div !== 12'd32) begin
         bad++;
         $display("FAIL reset_div: got %0d want 32", o_div);
      end
      ss = 1'b1;
      PRESET = 1'b0;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL reset_sb: got %h want %h", o, e); end
      end
   endtask

   task automatic test_fastest();
      logic [19:0] e, o;
      sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; ss = 1'b1;
      tick(); tick();
      ss = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         total++;
         if (o_sclk !== k[0] || o_smp !== !k[0] || o_shf !== k[0]) begin
            bad++;
            $display("FAIL fastest k=%0d: sclk/smp/shf=%b%b%b want %b%b%b",
                     k, o_sclk, o_smp, o_shf, k[0], !k[0], k[0]);
         end
      end
      total++;
      if (o_div !== 12'd2) begin bad++; $display("FAIL fastest_div: got %0d want 2", o_div); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL fastest_sb: got %h want %h", o, e); end
      end
   endtask

   task automatic test_divided();
      logic [19:0] e, o;
      logic prev;
      int   edges[$];
      ss = 1'b1; cpol = 1'b0; sppr = 3'd2; spr = 3'd1; cpha = 1'b1;
      tick();
      cpol = 1'b1;
      tick();
      total++;
      if (o_sclk !== 1'b0) begin bad++; $display("FAIL cpol_lag: got %b want 0", o_sclk); end
      tick();
      total++;
      if (o_sclk !== 1'b1) begin bad++; $display("FAIL cpol_idle: got %b want 1", o_sclk); end
      ss = 1'b0;
      prev = 1'b1;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (o_sclk !== prev) edges.push_back(k);
         prev = o_sclk;
         if (k == 5 || k == 17) begin
            total++;
            if (o_shf !== 1'b1 || o_smp !== 1'b0) begin
               bad++; $display("FAIL div_shift k=%0d: smp/shf=%b%b want 01", k, o_smp, o_shf);
            end
         end
         if (k == 11) begin
            total++;
            if (o_smp !== 1'b1 || o_shf !== 1'b0) begin
               bad++; $display("FAIL div_sample k=%0d: smp/shf=%b%b want 10", k, o_smp, o_shf);
            end
         end
      end
      total++;
      if (edges.size() != 4 || edges[0] != 6 || edges[1] != 12 || edges[2] != 18 || edges[3] != 24) begin
         bad++;
         $display("FAIL div_edges: count=%0d first=%0d want 4 edges at 6,12,18,24",
                  edges.size(), (edges.size() > 0) ? edges[0] : -1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL divided_sb: got %h want %h", o, e); end
      end
   endtask

   task automatic test_wait_stop();
      logic [19:0] e, o;
      ss = 1'b1; sppr = 3'd1; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; spi_mode = 2'b00;
      tick();
      ss = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      spi_mode = 2'b01; spiswai = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (o_sclk !== 1'b0 || o_smp !== 1'b0 || o_shf !== 1'b0) begin
            bad++; $display("FAIL wait_gate k=%0d: sclk/smp/shf=%b%b%b want 000", k, o_sclk, o_smp, o_shf);
         end
      end
      spiswai = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (o_sclk !== (k == 2)) begin
            bad++; $display("FAIL wait_resume k=%0d: sclk=%b want %b", k, o_sclk, (k == 2));
         end
      end
      spi_mode = 2'b11;
      tick(); tick();
      total++;
      if (o_sclk !== 1'b0) begin bad++; $display("FAIL stop11: sclk=%b want 0", o_sclk); end
      spi_mode = 2'b10;
      tick(); tick();
      spi_mode = 2'b00;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL wait_sb: got %h want %h", o, e); end
      end
   endtask

   task automatic test_abort_shrink();
      logic [19:0] e, o;
      ss = 1'b1; sppr = 3'd3; spr = 3'd1; cpol = 1'b0; cpha = 1'b0;
      tick();
      ss = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      sppr = 3'd1; spr = 3'd0;
      tick();
      total++;
      if (o_smp !== 1'b1 || o_sclk !== 1'b0) begin
         bad++; $display("FAIL shrink_term: smp=%b sclk=%b want 1 0", o_smp, o_sclk);
      end
      tick();
      total++;
      if (o_sclk !== 1'b1) begin bad++; $display("FAIL shrink_toggle: sclk=%b want 1", o_sclk); end
      ss = 1'b1;
      tick();
      total++;
      if (o_shf !== 1'b1 || o_smp !== 1'b0) begin
         bad++; $display("FAIL abort_strobe: smp/shf=%b%b want 01", o_smp, o_shf);
      end
      tick();
      total++;
      if (o_sclk !== 1'b0 || o_smp !== 1'b0 || o_shf !== 1'b0) begin
         bad++; $display("FAIL abort_idle: sclk/smp/shf=%b%b%b want 000", o_sclk, o_smp, o_shf);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL abort_sb: got %h want %h", o, e); end
      end
   endtask

`ifdef SPI_BRG_EDGE_CNT_EN
   task automatic test_edge_cnt();
      logic [19:0] e, o;
      ss = 1'b1; sppr = 3'd0; spr = 3'd0; cpol = 1'b0;
      tick();
      ss = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      total++;
      if (o_edge !== 5'd16) begin bad++; $display("FAIL edge_sat: got %0d want 16", o_edge); end
      ss = 1'b1;
      tick(); tick();
      total++;
      if (o_edge !== 5'd0) begin bad++; $display("FAIL edge_clr: got %0d want 0", o_edge); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) begin bad++; $display("FAIL edge_sb: got %h want %h", o, e); end
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET = 1'b1; spi_mode = 2'b00; spiswai = 1'b0; sppr = 3'd0; spr = 3'd0;
      cpol = 1'b0; cpha = 1'b0; ss = 1'b1;
      @(negedge PCLK);
      test_reset();
      test_fastest();
      test_divided();
      test_wait_stop();
      test_abort_shrink();
`ifdef SPI_BRG_EDGE_CNT_EN
      test_edge_cnt();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
